// File: rtl/unidad_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, mux selects.
// The ADDI states only exist in builds that define UC_ADDI_EN.
package unidad_control_pkg;

    localparam logic [3:0] ST_RESET     = 4'd0;
    localparam logic [3:0] ST_FETCH     = 4'd1;
    localparam logic [3:0] ST_DECODE    = 4'd2;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
    localparam logic [3:0] ST_MEM_RD    = 4'd4;
    localparam logic [3:0] ST_MEM_WB    = 4'd5;
    localparam logic [3:0] ST_MEM_WR    = 4'd6;
    localparam logic [3:0] ST_R_EXEC    = 4'd7;
    localparam logic [3:0] ST_R_WB      = 4'd8;
    localparam logic [3:0] ST_BRANCH    = 4'd9;
    localparam logic [3:0] ST_JUMP      = 4'd10;
    localparam logic [3:0] ST_ADDI_EXEC = 4'd11;
    localparam logic [3:0] ST_ADDI_WB   = 4'd12;

    typedef enum logic [3:0] {
        S_RESET     = ST_RESET,
        S_FETCH     = ST_FETCH,
        S_DECODE    = ST_DECODE,
        S_MEM_ADDR  = ST_MEM_ADDR,
        S_MEM_RD    = ST_MEM_RD,
        S_MEM_WB    = ST_MEM_WB,
        S_MEM_WR    = ST_MEM_WR,
        S_R_EXEC    = ST_R_EXEC,
        S_R_WB      = ST_R_WB,
        S_BRANCH    = ST_BRANCH,
        S_JUMP      = ST_JUMP
`ifdef UC_ADDI_EN
        ,
        S_ADDI_EXEC = ST_ADDI_EXEC,
        S_ADDI_WB   = ST_ADDI_WB
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_is_load(input logic [5:0] op);
        return op == OP_LW;
    endfunction

endpackage

// File: rtl/unidad_control_mc_dec.sv
// Control word decoder: state (plus mem_ready in FETCH) to datapath controls.
// Latency: combinational. Backpressure: mem_ready only gates the FETCH IR/PC loads.
// ADDI states decoded only when UC_ADDI_EN is defined.
module unidad_control_mc_dec
    import unidad_control_pkg::*;
(
    input  state_t   state,
    input  logic     mem_ready,
    output ctrl_t    ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC+4 load only on the cycle the word actually arrives
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
`ifdef UC_ADDI_EN
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS control FSM; opcode 8 (addi) supported when UC_ADDI_EN is defined.
// Latency: Moore outputs from state; IR/PC loads in FETCH follow mem_ready combinationally.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with stable requests until mem_ready=1.
module unidad_control_multiciclo
    import unidad_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] inst,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       illegal;
    ctrl_t      ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= inst;
        end
    end

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (inst)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef UC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default: begin
                        // PC already advanced in FETCH, so just move on
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = op_is_load(op_q) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef UC_ADDI_EN
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
`endif
            default:    state_d = S_RESET;
        endcase
    end

    unidad_control_mc_dec u_dec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = illegal;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Bench for unidad_control_multiciclo: per-instruction expected control traces built from
// instruction type and memory wait counts, compared cycle by cycle against the DUT.
module tb_unidad_control_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] inst = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;

    int checks = 0;
    int failures = 0;

    unidad_control_multiciclo dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    logic [17:0] obs;
    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

    localparam logic [17:0] W_ZERO       = 18'd0;
    localparam logic [17:0] W_FETCH_WAIT = {10'b0001000000, 2'b01, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] W_FETCH_GO   = {10'b1001010000, 2'b01, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] W_DECODE     = {10'b0000000000, 2'b11, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] W_DECODE_ILL = {10'b0000000000, 2'b11, 3'b000, 2'b00, 1'b1};
    localparam logic [17:0] W_MEM_ADDR   = {10'b0000000001, 2'b10, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] W_MEM_RD     = {10'b0011000000, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] W_MEM_WB     = {10'b0000001010, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] W_MEM_WR     = {10'b0010100000, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] W_R_EXEC     = {10'b0000000001, 2'b00, 3'b010, 2'b00, 1'b0};
    localparam logic [17:0] W_R_WB       = {10'b0000000110, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] W_BRANCH     = {10'b0100000001, 2'b00, 3'b001, 2'b01, 1'b0};
    localparam logic [17:0] W_JUMP       = {10'b1000000000, 2'b00, 3'b000, 2'b10, 1'b0};
    localparam logic [17:0] W_ADDI_EXEC  = {10'b0000000001, 2'b10, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] W_ADDI_WB    = {10'b0000000010, 2'b00, 3'b000, 2'b00, 1'b0};

    typedef struct packed {
        logic        rdy;
        logic [5:0]  in;
        logic [17:0] word;
    } step_t;

    step_t exp_q[$];

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic void push(input logic rdy, input logic [5:0] in, input logic [17:0] w);
        step_t s;
        s.rdy = rdy; s.in = in; s.word = w;
        exp_q.push_back(s);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
`ifdef UC_ADDI_EN
        return op == 0 || op == 35 || op == 43 || op == 4 || op == 2 || op == 8;
`else
        return op == 0 || op == 35 || op == 43 || op == 4 || op == 2;
`endif
    endfunction

    // Reference trace: fetch waits, fetch, decode, then the per-opcode steps.
    // inst is only meaningful in DECODE; mem_ready is random wherever it must be ignored.
    function automatic void model_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(1'b0, rop(), W_FETCH_WAIT);
        push(1'b1, rop(), W_FETCH_GO);
        if (!is_legal(op)) begin
            push(rbit(), op, W_DECODE_ILL);
            return;
        end
        push(rbit(), op, W_DECODE);
        case (op)
            6'd0: begin push(rbit(), rop(), W_R_EXEC); push(rbit(), rop(), W_R_WB); end
            6'd35: begin
                push(rbit(), rop(), W_MEM_ADDR);
                for (int i = 0; i < mw; i++) push(1'b0, rop(), W_MEM_RD);
                push(1'b1, rop(), W_MEM_RD);
                push(rbit(), rop(), W_MEM_WB);
            end
            6'd43: begin
                push(rbit(), rop(), W_MEM_ADDR);
                for (int i = 0; i < mw; i++) push(1'b0, rop(), W_MEM_WR);
                push(1'b1, rop(), W_MEM_WR);
            end
            6'd4: push(rbit(), rop(), W_BRANCH);
            6'd2: push(rbit(), rop(), W_JUMP);
            default: begin push(rbit(), rop(), W_ADDI_EXEC); push(rbit(), rop(), W_ADDI_WB); end
        endcase
    endfunction

    task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw);
        step_t s;
        int cyc;
        model_instr(op, fw, mw);
        cyc = 0;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            mem_ready = s.rdy;
            inst = s.in;
            @(negedge clk);
            checks++;
            if (obs !== s.word) begin
                failures++;
                $display("FAIL %s op=%0d cycle=%0d: controls=%b required=%b", name, op, cyc, obs, s.word);
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        inst = 6'd0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== W_ZERO) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d: controls=%b required=%b", i, obs, W_ZERO);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== W_ZERO) begin
            failures++;
            $display("FAIL reset_release: controls=%b required=%b", obs, W_ZERO);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();      run_instr("rtype", 6'd0, 0, 0);  endtask
    task automatic test_lw_wait();    run_instr("lw_wait", 6'd35, 0, 2); endtask
    task automatic test_fetch_wait(); run_instr("fetch_wait", 6'd0, 3, 0); endtask

    task automatic test_sw_beq_j();
        run_instr("sw", 6'd43, 0, 0);
        run_instr("beq", 6'd4, 0, 0);
        run_instr("j", 6'd2, 0, 0);
    endtask

    task automatic test_addi();
        run_instr("addi", 6'd8, 0, 0);
        run_instr("illegal63", 6'd63, 1, 0);
    endtask

    task automatic test_reset_mid_write();
        run_instr("sw_pre", 6'd43, 0, 0);
        mem_ready = 1'b1; inst = 6'd43;
        @(posedge clk); #1;            // FETCH -> DECODE
        @(posedge clk); #1;            // DECODE -> MEM_ADDR
        inst = 6'd0;
        @(posedge clk); #1;            // MEM_ADDR -> MEM_WR
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== W_MEM_WR) begin
            failures++;
            $display("FAIL rst_mid_wr_before: controls=%b required=%b", obs, W_MEM_WR);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== W_ZERO) begin
            failures++;
            $display("FAIL rst_mid_wr_drop: controls=%b required=%b", obs, W_ZERO);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== W_ZERO) begin
            failures++;
            $display("FAIL rst_mid_wr_reset_state: controls=%b required=%b", obs, W_ZERO);
        end
        @(posedge clk); #1;
        run_instr("after_rst", 6'd35, 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] legal_ops [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2};
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'd8;
                1: op = rop();
                default: op = legal_ops[$urandom_range(0, 4)];
            endcase
            run_instr("random", op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== W_FETCH_WAIT) begin
            failures++;
            $display("FAIL final_fetch: controls=%b required=%b", obs, W_FETCH_WAIT);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_beq_j();
        test_fetch_wait();
        test_addi();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
